// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM checker refresh scheduler: state
// encodings, default timing parameters and debt counter width.
package jtsdram_pkg;

    localparam int DEF_TICK_DIV  = 375;
    localparam int DEF_HIGH_MARK = 12;
    localparam int DEF_LOW_MARK  = 4;

    localparam int DEBT_W = 4;
    localparam logic [DEBT_W-1:0] DEBT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_FORCE = 2'd2,
        ST_DWNLD = 2'd3
    } rfsh_state_t;

endpackage

// File: rtl/jtsdram_rfsh_ctrl_if.sv
// Signal bundle between the refresh scheduler and the rest of the checker.
// The master drives video/download/ack inputs; the slave is the scheduler.
interface jtsdram_rfsh_ctrl_if;
    import jtsdram_pkg::*;

    logic              LVBL;
    logic              dwnld_busy;
    logic              prog_rfsh;
    logic              rfsh_ack;
    logic              refresh_en;
    logic              urgent;
    logic [DEBT_W-1:0] debt;
    logic              overflow;
    logic [7:0]        force_cnt;

    modport master (
        output LVBL, dwnld_busy, prog_rfsh, rfsh_ack,
        input  refresh_en, urgent, debt, overflow, force_cnt
    );

    modport slave (
        input  LVBL, dwnld_busy, prog_rfsh, rfsh_ack,
        output refresh_en, urgent, debt, overflow, force_cnt
    );

endinterface

// File: rtl/jtsdram_rfsh_debt.sv
// Refresh obligation tracker: a free-running tick divider feeding a
// saturating up/down debt counter with a sticky overflow flag.
module jtsdram_rfsh_debt
    import jtsdram_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rfsh_ack,
    output logic [DEBT_W-1:0] debt,
    output logic              overflow
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_reg, tick_next;
    logic              tick_p;
    logic [DEBT_W-1:0] debt_reg, debt_next;
    logic              overflow_reg, overflow_next;

    always_comb begin
        tick_p        = (tick_reg == TICK_LAST);
        tick_next     = tick_p ? '0 : tick_reg + TICK_W'(1);
        debt_next     = debt_reg;
        overflow_next = overflow_reg;
        // A tick and an ack in the same cycle cancel out, even at the limits.
        if (tick_p && !rfsh_ack) begin
            if (debt_reg == DEBT_MAX)
                overflow_next = 1'b1;
            else
                debt_next = debt_reg + DEBT_W'(1);
        end else if (rfsh_ack && !tick_p && debt_reg != '0) begin
            debt_next = debt_reg - DEBT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_reg     <= '0;
            debt_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            tick_reg     <= tick_next;
            debt_reg     <= debt_next;
            overflow_reg <= overflow_next;
        end
    end

    assign debt     = debt_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/jtsdram_rfsh_ctrl.sv
// Refresh scheduler: refreshes opportunistically in vertical blank, forces
// refresh when debt piles up, and passes the programming request in download.
module jtsdram_rfsh_ctrl
    import jtsdram_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int HIGH_MARK = DEF_HIGH_MARK,
    parameter int LOW_MARK  = DEF_LOW_MARK
) (
    input  logic               clk,
    input  logic               rst_n,
    jtsdram_rfsh_ctrl_if.slave rfsh
);

    rfsh_state_t       state_reg, state_next;
    logic              refresh_en_reg, refresh_en_next;
    logic              urgent_reg, urgent_next;
    logic [7:0]        force_cnt_reg, force_cnt_next;
    logic [DEBT_W-1:0] debt;
    logic              overflow;
    logic              debt_hi, debt_lo, debt_nz;

    jtsdram_rfsh_debt #(
        .TICK_DIV (TICK_DIV)
    ) u_debt (
        .clk      (clk),
        .rst_n    (rst_n),
        .rfsh_ack (rfsh.rfsh_ack),
        .debt     (debt),
        .overflow (overflow)
    );

    // Decisions use the registered debt, before this cycle's tick/ack lands.
    assign debt_hi = int'(debt) >= HIGH_MARK;
    assign debt_lo = int'(debt) <= LOW_MARK;
    assign debt_nz = debt != '0;

    always_comb begin
        state_next = state_reg;
        if (rfsh.dwnld_busy) begin
            state_next = ST_DWNLD;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (debt_hi)
                        state_next = ST_FORCE;
                    else if (debt_nz && !rfsh.LVBL)
                        state_next = ST_BLANK;
                end
                ST_BLANK: begin
                    if (debt_hi)
                        state_next = ST_FORCE;
                    else if (!debt_nz || rfsh.LVBL)
                        state_next = ST_IDLE;
                end
                ST_FORCE: begin
                    if (debt_lo)
                        state_next = rfsh.LVBL ? ST_IDLE : ST_BLANK;
                end
                ST_DWNLD: state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end

        // Outputs are registered from the next state for one-cycle latency.
        refresh_en_next = (state_next == ST_BLANK) || (state_next == ST_FORCE)
                       || (state_next == ST_DWNLD && rfsh.prog_rfsh);
        urgent_next     = (state_next == ST_FORCE);

        force_cnt_next = force_cnt_reg;
        if (state_next == ST_FORCE && state_reg != ST_FORCE && force_cnt_reg != 8'hFF)
            force_cnt_next = force_cnt_reg + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            refresh_en_reg <= 1'b0;
            urgent_reg     <= 1'b0;
            force_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            refresh_en_reg <= refresh_en_next;
            urgent_reg     <= urgent_next;
            force_cnt_reg  <= force_cnt_next;
        end
    end

    assign rfsh.refresh_en = refresh_en_reg;
    assign rfsh.urgent     = urgent_reg;
    assign rfsh.debt       = debt;
    assign rfsh.overflow   = overflow;
    assign rfsh.force_cnt  = force_cnt_reg;

endmodule

// File: tb/tb_jtsdram_rfsh_ctrl.sv
// Directed bench for the refresh scheduler with TICK_DIV=4: debt increments
// on every 4th clock edge after reset release, expectations computed by hand.
module tb_jtsdram_rfsh_ctrl;
    import jtsdram_pkg::*;

    typedef struct {
        int lvbl;
        int busy;
        int prog;
        int ack;
        int cycles;
        int ref_e;
        int urg_e;
        int debt_e;
        int ovf_e;
        int fc_e;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];

    jtsdram_rfsh_ctrl_if rfsh();

    jtsdram_rfsh_ctrl #(
        .TICK_DIV  (4),
        .HIGH_MARK (12),
        .LOW_MARK  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rfsh  (rfsh)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int lvbl, int busy, int prog, int ack, int cycles,
                                int ref_e, int urg_e, int debt_e, int ovf_e, int fc_e);
        vec_t v;
        v.lvbl = lvbl; v.busy = busy; v.prog = prog; v.ack = ack; v.cycles = cycles;
        v.ref_e = ref_e; v.urg_e = urg_e; v.debt_e = debt_e; v.ovf_e = ovf_e; v.fc_e = fc_e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".refresh_en"}, 32'(rfsh.refresh_en), v.ref_e);
        chk({tag, ".urgent"},     32'(rfsh.urgent),     v.urg_e);
        chk({tag, ".debt"},       32'(rfsh.debt),       v.debt_e);
        chk({tag, ".overflow"},   32'(rfsh.overflow),   v.ovf_e);
        chk({tag, ".force_cnt"},  32'(rfsh.force_cnt),  v.fc_e);
        $display("%s: refresh_en=%0d urgent=%0d debt=%0d overflow=%0d force_cnt=%0d",
                 tag, rfsh.refresh_en, rfsh.urgent, rfsh.debt, rfsh.overflow, rfsh.force_cnt);
    endtask

    // Inputs change at a falling edge; outputs are checked at a falling edge.
    task automatic drive(input vec_t v);
        rfsh.LVBL       = v.lvbl[0];
        rfsh.dwnld_busy = v.busy[0];
        rfsh.prog_rfsh  = v.prog[0];
        rfsh.rfsh_ack   = v.ack[0];
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v);
        repeat (v.cycles) @(negedge clk);
        chk_all(tag, v);
    endtask

    initial begin
        vec_t v;

        //            lvbl busy prog ack cyc  ref urg debt ovf fc      edges after release
        tbl.push_back(mk(1, 0, 0, 0, 24,  0, 0,  6, 0, 0)); // 1..24   idle accrual
        tbl.push_back(mk(0, 0, 0, 0,  1,  1, 0,  6, 0, 0)); // 25      enter BLANK
        tbl.push_back(mk(0, 0, 0, 1,  3,  1, 0,  4, 0, 0)); // 26..28  tick+ack at 28
        tbl.push_back(mk(0, 0, 0, 1,  4,  1, 0,  1, 0, 0)); // 29..32
        tbl.push_back(mk(0, 0, 0, 1,  1,  1, 0,  0, 0, 0)); // 33      debt hits 0
        tbl.push_back(mk(0, 0, 0, 0,  1,  0, 0,  0, 0, 0)); // 34      BLANK -> IDLE
        tbl.push_back(mk(1, 0, 0, 1,  1,  0, 0,  0, 0, 0)); // 35      ack at debt 0
        tbl.push_back(mk(1, 0, 0, 0,  1,  0, 0,  1, 0, 0)); // 36      tick
        tbl.push_back(mk(1, 0, 0, 0, 16,  0, 0,  5, 0, 0)); // 37..52
        tbl.push_back(mk(1, 0, 0, 0,  3,  0, 0,  5, 0, 0)); // 53..55
        tbl.push_back(mk(1, 0, 0, 1,  1,  0, 0,  5, 0, 0)); // 56      tick+ack at 5
        tbl.push_back(mk(1, 0, 0, 0, 28,  0, 0, 12, 0, 0)); // 57..84  debt reaches 12
        tbl.push_back(mk(1, 0, 0, 0,  1,  1, 1, 12, 0, 1)); // 85      FORCE
        tbl.push_back(mk(1, 0, 0, 1, 10,  1, 1,  4, 0, 1)); // 86..95  drain to 4
        tbl.push_back(mk(1, 0, 0, 0,  1,  0, 0,  5, 0, 1)); // 96      FORCE -> IDLE
        tbl.push_back(mk(1, 0, 0, 0, 40,  1, 1, 15, 0, 2)); // 97..136 FORCE again
        tbl.push_back(mk(1, 0, 0, 0,  4,  1, 1, 15, 1, 2)); // 137..140 lost tick
        tbl.push_back(mk(1, 0, 0, 1,  1,  1, 1, 14, 1, 2)); // 141     overflow sticky

        rfsh.LVBL = 1'b1; rfsh.dwnld_busy = 1'b0; rfsh.prog_rfsh = 1'b0; rfsh.rfsh_ack = 1'b0;

        repeat (3) @(negedge clk);
        chk_all("reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // Download passthrough: the request shows up one edge later, never earlier.
        apply("dwnld_enter", mk(1, 1, 0, 0, 1, 0, 0, 14, 1, 2));   // 142
        v = mk(1, 1, 1, 0, 1, 1, 0, 14, 1, 2);
        drive(v);
        #1 chk("dwnld_pre_edge.refresh_en", 32'(rfsh.refresh_en), 32'd0);
        @(negedge clk);
        chk_all("dwnld_prog1", v);                                    // 143
        apply("dwnld_prog0", mk(1, 1, 0, 0, 1, 0, 0, 15, 1, 2));    // 144 tick
        apply("dwnld_prog1b", mk(1, 1, 1, 0, 1, 1, 0, 15, 1, 2));   // 145
        apply("dwnld_exit", mk(1, 0, 0, 0, 1, 0, 0, 15, 1, 2));     // 146 IDLE
        apply("refore", mk(1, 0, 0, 0, 1, 1, 1, 15, 1, 3));         // 147 FORCE

        // Asynchronous reset mid-FORCE, checked well before the next rising edge.
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst3", mk(1, 0, 0, 0, 3, 0, 0, 0, 0, 0));
        apply("post_rst4", mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
